// File: rtl/pipe_em_n.sv
// EX/MEM pipeline register for LANES issue lanes with lane qualification,
// same-destination write squash, stall/flush control and saturating event counters.
module pipe_em_n #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DW    = 32,
  parameter int unsigned RW    = 5,
  parameter int unsigned CW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LANES-1:0]    valid_e,
  input  logic [LANES-1:0]    regwrite_e,
  input  logic [LANES-1:0]    memtoreg_e,
  input  logic [LANES-1:0]    memwrite_e,
  input  logic [LANES*RW-1:0] writereg_e,
  input  logic [LANES*DW-1:0] aluout_e,
  input  logic [LANES*DW-1:0] writedata_e,
  input  logic                stall_m,
  input  logic                flush_m,
  output logic [LANES-1:0]    valid_m,
  output logic [LANES-1:0]    regwrite_m,
  output logic [LANES-1:0]    memtoreg_m,
  output logic [LANES-1:0]    memwrite_m,
  output logic [LANES*RW-1:0] writereg_m,
  output logic [LANES*DW-1:0] aluout_m,
  output logic [LANES*DW-1:0] writedata_m,
  output logic [CW-1:0]       stall_cnt,
  output logic [CW-1:0]       flush_cnt
);

  localparam logic [CW-1:0] CntOne = CW'(1);

  logic [LANES-1:0] rw_live;
  logic [LANES-1:0] regwrite_ld;

  // A lane's register write survives only if no higher lane writes the same register.
  always_comb begin
    rw_live     = '0;
    regwrite_ld = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      rw_live[i] = valid_e[i] & regwrite_e[i] & (writereg_e[i*RW +: RW] != '0);
    end
    regwrite_ld = rw_live;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (rw_live[i] && rw_live[j] && (writereg_e[i*RW +: RW] == writereg_e[j*RW +: RW])) begin
          regwrite_ld[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_m     <= '0;
      regwrite_m  <= '0;
      memtoreg_m  <= '0;
      memwrite_m  <= '0;
      writereg_m  <= '0;
      aluout_m    <= '0;
      writedata_m <= '0;
    end else if (flush_m) begin
      // Payload is left in place; only the control bits are squashed.
      valid_m    <= '0;
      regwrite_m <= '0;
      memtoreg_m <= '0;
      memwrite_m <= '0;
    end else if (!stall_m) begin
      valid_m     <= valid_e;
      regwrite_m  <= regwrite_ld;
      memtoreg_m  <= memtoreg_e & valid_e;
      memwrite_m  <= memwrite_e & valid_e;
      writereg_m  <= writereg_e;
      aluout_m    <= aluout_e;
      writedata_m <= writedata_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush_m) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CntOne;
      end else if (stall_m) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_pipe_em_n.sv
// Randomized bench for pipe_em_n against a lane-level behavioural model; a second
// instance with CW=4 shares the inputs to exercise counter saturation.
module tb_pipe_em_n;
  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int CW    = 16;
  localparam int CWS   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [LANES-1:0]    valid_e = '0, regwrite_e = '0, memtoreg_e = '0, memwrite_e = '0;
  logic [LANES*RW-1:0] writereg_e = '0;
  logic [LANES*DW-1:0] aluout_e = '0, writedata_e = '0;
  logic                stall_m = 1'b0, flush_m = 1'b0;

  logic [LANES-1:0]    valid_m, regwrite_m, memtoreg_m, memwrite_m;
  logic [LANES*RW-1:0] writereg_m;
  logic [LANES*DW-1:0] aluout_m, writedata_m;
  logic [CW-1:0]       stall_cnt, flush_cnt;

  logic [LANES-1:0]    valid_s, regwrite_s, memtoreg_s, memwrite_s;
  logic [LANES*RW-1:0] writereg_s;
  logic [LANES*DW-1:0] aluout_s, writedata_s;
  logic [CWS-1:0]      stall_cnt_s, flush_cnt_s;

  always #5 clk = ~clk;

  pipe_em_n #(.LANES(LANES), .DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .writereg_e(writereg_e),
    .aluout_e(aluout_e), .writedata_e(writedata_e), .stall_m(stall_m), .flush_m(flush_m),
    .valid_m(valid_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
    .memwrite_m(memwrite_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
    .writedata_m(writedata_m), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_em_n #(.LANES(LANES), .DW(DW), .RW(RW), .CW(CWS)) dut_sat (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e), .regwrite_e(regwrite_e),
    .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .writereg_e(writereg_e),
    .aluout_e(aluout_e), .writedata_e(writedata_e), .stall_m(stall_m), .flush_m(flush_m),
    .valid_m(valid_s), .regwrite_m(regwrite_s), .memtoreg_m(memtoreg_s),
    .memwrite_m(memwrite_s), .writereg_m(writereg_s), .aluout_m(aluout_s),
    .writedata_m(writedata_s), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: one record per lane plus integer counters.
  logic          mv [LANES], mrw [LANES], mmr [LANES], mmw [LANES];
  logic [RW-1:0] mwr [LANES];
  logic [DW-1:0] mal [LANES], mwd [LANES];
  int            ms, mf, mss, mfs;

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      mv[i] = 0; mrw[i] = 0; mmr[i] = 0; mmw[i] = 0;
      mwr[i] = '0; mal[i] = '0; mwd[i] = '0;
    end
    ms = 0; mf = 0; mss = 0; mfs = 0;
  endtask

  task automatic model_edge();
    logic [RW-1:0] wr;
    bit keep;
    if (flush_m) begin
      for (int i = 0; i < LANES; i++) begin
        mv[i] = 0; mrw[i] = 0; mmr[i] = 0; mmw[i] = 0;
      end
      if (mf < (1 << CW) - 1) mf++;
      if (mfs < (1 << CWS) - 1) mfs++;
    end else if (stall_m) begin
      if (ms < (1 << CW) - 1) ms++;
      if (mss < (1 << CWS) - 1) mss++;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        wr = writereg_e[i*RW +: RW];
        mv[i]  = valid_e[i];
        mmr[i] = memtoreg_e[i] && valid_e[i];
        mmw[i] = memwrite_e[i] && valid_e[i];
        mwr[i] = wr;
        mal[i] = aluout_e[i*DW +: DW];
        mwd[i] = writedata_e[i*DW +: DW];
        keep = valid_e[i] && regwrite_e[i] && (wr != 0);
        // A later lane writing the same register takes the write.
        for (int j = i + 1; j < LANES; j++)
          if (valid_e[j] && regwrite_e[j] && writereg_e[j*RW +: RW] == wr) keep = 0;
        mrw[i] = keep;
      end
    end
  endtask

  task automatic check_all();
    logic [LANES-1:0] ev, erw, emr, emw;
    logic [LANES*RW-1:0] ewr;
    logic [LANES*DW-1:0] eal, ewd;
    for (int i = 0; i < LANES; i++) begin
      ev[i] = mv[i]; erw[i] = mrw[i]; emr[i] = mmr[i]; emw[i] = mmw[i];
      ewr[i*RW +: RW] = mwr[i]; eal[i*DW +: DW] = mal[i]; ewd[i*DW +: DW] = mwd[i];
    end
    check("valid_m", 64'(valid_m), 64'(ev));
    check("regwrite_m", 64'(regwrite_m), 64'(erw));
    check("memtoreg_m", 64'(memtoreg_m), 64'(emr));
    check("memwrite_m", 64'(memwrite_m), 64'(emw));
    check("writereg_m", 64'(writereg_m), 64'(ewr));
    check("aluout_m", 64'(aluout_m), 64'(eal));
    check("writedata_m", 64'(writedata_m), 64'(ewd));
    check("stall_cnt", 64'(stall_cnt), 64'(ms));
    check("flush_cnt", 64'(flush_cnt), 64'(mf));
    check("stall_cnt_sat", 64'(stall_cnt_s), 64'(mss));
    check("flush_cnt_sat", 64'(flush_cnt_s), 64'(mfs));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    valid_e    = LANES'($urandom);
    regwrite_e = LANES'($urandom);
    memtoreg_e = LANES'($urandom);
    memwrite_e = LANES'($urandom);
    for (int i = 0; i < LANES; i++) begin
      writereg_e[i*RW +: RW]  = RW'($urandom_range(0, 3));
      aluout_e[i*DW +: DW]    = $urandom;
      writedata_e[i*DW +: DW] = $urandom;
    end
  endtask

  initial begin
    int s0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // Basic two-lane load.
    valid_e = 2'b11; regwrite_e = 2'b11; memtoreg_e = 2'b00; memwrite_e = 2'b00;
    writereg_e = {5'd7, 5'd3}; aluout_e = {32'h22, 32'h11}; writedata_e = {32'hB, 32'hA};
    step();
    check("load_regwrite", 64'(regwrite_m), 64'h3);
    check("load_writereg", 64'(writereg_m), 64'({5'd7, 5'd3}));
    check("load_aluout", 64'(aluout_m), {32'h22, 32'h11});

    // Same destination: higher lane wins.
    writereg_e = {5'd9, 5'd9};
    step();
    check("squash_regwrite", 64'(regwrite_m), 64'h2);
    check("squash_valid", 64'(valid_m), 64'h3);
    writereg_e = {5'd0, 5'd4};
    step();
    check("zero_reg_regwrite", 64'(regwrite_m), 64'h1);

    // Three stall cycles with changing inputs.
    s0 = ms;
    stall_m = 1'b1;
    repeat (3) begin
      rand_inputs();
      step();
    end
    check("stall3_cnt", 64'(stall_cnt), 64'(s0 + 3));

    // Stall and flush together: flush wins.
    flush_m = 1'b1;
    step();
    check("sf_valid", 64'(valid_m), 64'h0);
    check("sf_stall_cnt", 64'(stall_cnt), 64'(s0 + 3));
    check("sf_flush_cnt", 64'(flush_cnt), 64'h1);
    flush_m = 1'b0;

    // Saturation on the narrow-counter instance.
    repeat (20) step();
    check("sat_stall_15", 64'(stall_cnt_s), 64'd15);
    repeat (2) step();
    check("sat_stall_hold", 64'(stall_cnt_s), 64'd15);

    // Load data, then reset asynchronously mid-cycle.
    stall_m = 1'b0;
    rand_inputs();
    valid_e = 2'b11;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_valid", 64'(valid_m), 64'h0);
    stall_m = 1'b1;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();
    step();
    stall_m = 1'b0;
    step();

    repeat (300) begin
      rand_inputs();
      stall_m = ($urandom_range(0, 4) == 0);
      flush_m = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_em_n.md
PIPE_EM_N -- requirements
Module: pipe_em_n

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes carried (1..4).
REQ-002 Parameter DW, default 32, ALU result / store data width.
REQ-003 Parameter RW, default 5, destination register index width.
REQ-004 Parameter CW, default 16, performance counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 valid_e  in  LANES  per-lane valid from EX; lane i is bit i.
REQ-008 regwrite_e, memtoreg_e, memwrite_e  in  LANES each  per-lane control bits.
REQ-009 writereg_e  in  LANES*RW  destination index; lane i at bits [i*RW +: RW].
REQ-010 aluout_e, writedata_e  in  LANES*DW each  ALU result and store data; lane i at [i*DW +: DW].
REQ-011 stall_m  in  1  hold all stage contents.
REQ-012 flush_m  in  1  squash all stage contents.
REQ-013 valid_m, regwrite_m, memtoreg_m, memwrite_m  out  LANES each  registered per-lane control.
REQ-014 writereg_m  out  LANES*RW; aluout_m, writedata_m  out  LANES*DW each  registered per-lane payload.
REQ-015 stall_cnt, flush_cnt  out  CW each  saturating event counters.

Function
REQ-016 Update priority per edge SHALL be: reset > flush_m > stall_m > load.
REQ-017 Load (flush_m=0, stall_m=0): all *_m outputs SHALL take the qualified *_e values one cycle later (latency 1).
REQ-018 Qualification: regwrite_m[i], memwrite_m[i], memtoreg_m[i] SHALL load as the corresponding *_e bit AND valid_e[i].
REQ-019 Zero-register suppression: regwrite_m[i] SHALL load 0 when writereg_e lane i equals 0.
REQ-020 Same-destination squash: when lanes i<j both have valid, regwrite_e=1, and equal nonzero writereg_e, regwrite_m[i] SHALL load 0 (highest-numbered lane wins); valid_m[i], memwrite_m[i], and payload are unaffected.
REQ-021 Stall (flush_m=0, stall_m=1): every output register SHALL hold its value.
REQ-022 Flush (flush_m=1, any stall_m): valid_m, regwrite_m, memtoreg_m, memwrite_m SHALL become 0; writereg_m, aluout_m, writedata_m SHALL hold.
REQ-023 stall_cnt SHALL increment by 1 on each edge with stall_m=1 and flush_m=0, saturating at 2^CW-1.
REQ-024 flush_cnt SHALL increment by 1 on each edge with flush_m=1, saturating at 2^CW-1; counters are never cleared except by reset.
REQ-025 Lanes SHALL be independent except for REQ-020; an invalid lane SHALL never write registers or memory downstream.

Reset
REQ-026 rst_n=0 SHALL immediately, without clock, force all outputs to 0 (control, payload, counters).
REQ-027 Reset SHALL be honoured mid-stall or mid-flush; first load occurs on the first rising edge with rst_n=1 and stall_m=0.
REQ-028 Reset deassertion SHALL take effect at the next rising edge; no output changes on deassertion itself.

Verification
REQ-029 Load: valid_e=2'b11, regwrite_e=2'b11, writereg lanes 3/7, aluout 0x11/0x22, no stall -> next cycle regwrite_m=2'b11, writereg_m 3/7, aluout_m 0x11/0x22.
REQ-030 Same-dest squash: both lanes valid, regwrite, writereg=9 -> regwrite_m=2'b10, valid_m=2'b11; writereg=0 on lane 1 -> regwrite_m[1]=0.
REQ-031 Stall 3 cycles with changing *_e -> outputs frozen at pre-stall values, stall_cnt increases by 3.
REQ-032 Simultaneous stall_m=1, flush_m=1 -> control outputs 0, aluout_m held, flush_cnt +1, stall_cnt unchanged.
REQ-033 Saturation: CW=4, 20 stall cycles -> stall_cnt=15 and remains 15.
REQ-034 Async reset mid-cycle with loaded data -> all outputs 0 before next clock edge; counters 0.
